div4_seq: RTL and testbench
===========================

DIV4_SEQ -- requirements
Module: div4_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port A, input, 4 bits: unsigned dividend, sampled only on an accepted start.
REQ-004 The block SHALL have port B, input, 4 bits: unsigned divisor, sampled only on an accepted start.
REQ-005 The block SHALL have port start, input, 1 bit: request a division; accepted only in IDLE.
REQ-006 The block SHALL have port Q, output, 4 bits: quotient, registered.
REQ-007 The block SHALL have port R, output, 4 bits: remainder, registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high from the cycle after acceptance until done is asserted.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that Q/R are valid.
REQ-010 The block SHALL have port DZ, output, 1 bit: divide-by-zero flag; present only with DIV4_DZ_EN (REQ-027).

Function
REQ-011 The block SHALL compute Q = A / B and R = A mod B using unsigned restoring division, one quotient bit per cycle, MSB first.
REQ-012 The FSM SHALL have exactly the states IDLE, RUN, and FIN.
REQ-013 In IDLE with start=1 at a clock edge, the block SHALL:
- latch A and B;
- clear the 5-bit partial remainder and the 2-bit iteration counter;
- enter RUN.
REQ-014 Each RUN cycle SHALL perform the following steps:
- shift the partial remainder left by one, inserting the next dividend bit (A[3] first);
- trial-subtract the latched B;
- if the result is non-negative, keep the difference and set the quotient bit to 1;
- otherwise restore the partial remainder and set the quotient bit to 0.
REQ-015 RUN SHALL last exactly 4 cycles (counter 0..3); the counter SHALL wrap from 3 to 0 on the transition to FIN.
REQ-016 In FIN, the block SHALL load Q and R, assert done for exactly one cycle, and return to IDLE on the next edge.
REQ-017 Latency SHALL be fixed: done is high in the 6th cycle after the start-sampling edge (1 cycle to latch, 4 RUN cycles, 1 FIN cycle).
REQ-018 busy SHALL be high in RUN and FIN, and low in IDLE.
REQ-019 A start asserted while busy=1 SHALL be ignored, with no effect on the operation in progress or its results.
REQ-020 start=1 in the same cycle that done=1 SHALL NOT be accepted; it SHALL be accepted on the following cycle (IDLE).
REQ-021 Q and R SHALL hold their last values from FIN until the next FIN or reset; they SHALL NOT change during RUN.
REQ-022 With B=0 and no DIV4_DZ_EN, the algorithm SHALL naturally yield Q=4'hF and R=A with normal latency.

Reset
REQ-023 While reset=1, the block SHALL immediately, independent of clk, force:
- the state to IDLE;
- Q=0, R=0, busy=0, done=0, DZ=0;
- the counter and partial remainder to 0.
REQ-024 Reset asserted mid-operation SHALL abort the division with no done pulse; the first start after release SHALL be processed normally.
REQ-025 On the first edge after reset deasserts, the block SHALL be able to accept start.

Configuration
REQ-026 Macro DIV4_DZ_EN SHALL select divide-by-zero handling.
REQ-027 With DIV4_DZ_EN defined, the block SHALL behave as follows:
- the DZ port exists;
- B=0 at acceptance SHALL skip RUN (IDLE->FIN) and load Q=4'hF, R=A, DZ=1;
- done SHALL assert in the 2nd cycle after the start-sampling edge;
- DZ SHALL clear to 0 at the next FIN with B!=0, and SHALL otherwise hold like Q/R.
REQ-028 With DIV4_DZ_EN undefined, the DZ port SHALL be absent, and B=0 SHALL follow REQ-022 with normal 6-cycle latency.

Verification
REQ-029 The bench SHALL apply A=13, B=4, start pulse and check:
- busy is high for 5 cycles;
- done pulses once in the 6th cycle with Q=3, R=1.
REQ-030 The bench SHALL cover the following divider boundary cases:
- A=15, B=1 -> Q=15, R=0;
- A=3, B=7 -> Q=0, R=3;
- A=0, B=5 -> Q=0, R=0.
REQ-031 The bench SHALL apply A=9, B=0 and check the result in both builds:
- DIV4_DZ_EN build: done at cycle 2 with Q=15, R=9, DZ=1; a following 8/2 gives Q=4, R=0, DZ=0;
- build without DIV4_DZ_EN: done at cycle 6 with Q=15, R=9.
REQ-032 The bench SHALL start 14/3, pulse start with A=1, B=1 during RUN, and check the single done gives Q=4, R=2.
REQ-033 The bench SHALL start 12/5, assert reset asynchronously during RUN, and check:
- outputs go to 0 immediately;
- no done pulse occurs;
- a following 12/5 gives Q=2, R=2.
REQ-034 The bench SHALL hold start high continuously with 10/3 and check:
- one done pulse per 7 cycles (re-accept in the cycle after done);
- every result is Q=3, R=1.

Source files
------------

// File: rtl/div4_seq_if.sv
// Handshake/data bundle for the 4-bit sequential divider.
// DZ exists only when DIV4_DZ_EN is defined.
interface div4_seq_if;
  logic [3:0] A;
  logic [3:0] B;
  logic       start;
  logic [3:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
`ifdef DIV4_DZ_EN
  logic       DZ;

  modport master (output A, B, start, input Q, R, busy, done, DZ);
  modport slave  (input A, B, start, output Q, R, busy, done, DZ);
`else
  modport master (output A, B, start, input Q, R, busy, done);
  modport slave  (input A, B, start, output Q, R, busy, done);
`endif
endinterface

// File: rtl/div4_seq.sv
// 4-bit unsigned restoring divider, one quotient bit per cycle, MSB first.
// Optional divide-by-zero short-cut and DZ flag selected by macro DIV4_DZ_EN.
module div4_seq (
  input  logic        clk,
  input  logic        reset,
  div4_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             r_state;
  logic [3:0]         r_a;
  logic [3:0]         r_b;
  logic [4:0]         r_prem;
  logic [3:0]         r_quo;
  logic [1:0]         r_cnt;
  logic [3:0]         r_q;
  logic [3:0]         r_r;
  logic               r_busy;
  logic               r_done;
`ifdef DIV4_DZ_EN
  logic               r_dz;
  logic               r_dz_pend;
`endif

  logic signed [5:0]  w_shift;
  logic signed [5:0]  w_diff;
  logic               w_qbit;

  // Partial remainder stays below B, so 6 signed bits hold shift and trial difference.
  assign w_shift = {r_prem, r_a[3]};
  assign w_diff  = w_shift - signed'({2'b00, r_b});
  assign w_qbit  = ~w_diff[5];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_a       <= 4'd0;
      r_b       <= 4'd0;
      r_prem    <= 5'd0;
      r_quo     <= 4'd0;
      r_cnt     <= 2'd0;
      r_q       <= 4'd0;
      r_r       <= 4'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef DIV4_DZ_EN
      r_dz      <= 1'b0;
      r_dz_pend <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // The done cycle is spent in IDLE; a start seen alongside done waits one cycle.
          if (bus.start && !r_done) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_prem  <= 5'd0;
            r_quo   <= 4'd0;
            r_cnt   <= 2'd0;
            r_busy  <= 1'b1;
            r_state <= RUN;
`ifdef DIV4_DZ_EN
            r_dz_pend <= 1'b0;
            if (bus.B == 4'd0) begin
              r_quo     <= 4'hF;
              r_prem    <= {1'b0, bus.A};
              r_dz_pend <= 1'b1;
              r_state   <= FIN;
            end
`endif
          end
        end
        RUN: begin
          r_prem  <= w_qbit ? w_diff[4:0] : w_shift[4:0];
          r_quo   <= {r_quo[2:0], w_qbit};
          r_a     <= {r_a[2:0], 1'b0};
          r_cnt   <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          r_q     <= r_quo;
          r_r     <= r_prem[3:0];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
`ifdef DIV4_DZ_EN
          r_dz    <= r_dz_pend;
`endif
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Q    = r_q;
  assign bus.R    = r_r;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
`ifdef DIV4_DZ_EN
  assign bus.DZ   = r_dz;
`endif

endmodule

// File: tb/tb_div4_seq.sv
// Directed bench for div4_seq; expectations are hand-computed quotients/remainders and cycle counts.
// Define DIV4_DZ_EN for both bench and RTL to exercise the divide-by-zero build.
module tb_div4_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div4_seq_if bus ();

  div4_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;
  int last_q   = 0;
  int cyc;
  int nb;
  int ndone;
  logic saw_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with a one-cycle start pulse; returns in cycle 1 after acceptance.
  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int c, output int busy_cnt);
    c = c0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && c <= 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      c++;
    end
  endtask

  task automatic run_div(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input int lat, input int eq, input int er);
    int c;
    int bc;
    launch(a, b);
    wait_done(1, c, bc);
    chk($sformatf("%s latency", tag), c, lat);
    chk($sformatf("%s busy cycles", tag), bc, lat - 1);
    chk($sformatf("%s Q", tag), bus.Q, eq);
    chk($sformatf("%s R", tag), bus.R, er);
    tick();
    chk($sformatf("%s done single pulse", tag), bus.done, 0);
  endtask

  initial begin
    bus.A     = 4'd0;
    bus.B     = 4'd0;
    bus.start = 1'b0;
    reset     = 1'b1;
    #12;
    chk("reset Q", bus.Q, 0);
    chk("reset R", bus.R, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
`ifdef DIV4_DZ_EN
    chk("reset DZ", bus.DZ, 0);
`endif
    @(posedge clk);
    #3 reset = 1'b0;

    // Start is presented on the very first edge after reset release.
    run_div("13/4", 4'd13, 4'd4, 6, 3, 1);
    run_div("15/1", 4'd15, 4'd1, 6, 15, 0);
    run_div("3/7",  4'd3,  4'd7, 6, 0, 3);
    run_div("0/5",  4'd0,  4'd5, 6, 0, 0);

`ifdef DIV4_DZ_EN
    run_div("9/0 dz", 4'd9, 4'd0, 2, 15, 9);
    chk("9/0 DZ set", bus.DZ, 1);
    run_div("8/2", 4'd8, 4'd2, 6, 4, 0);
    chk("8/2 DZ cleared", bus.DZ, 0);
    last_q = 4;
`else
    run_div("9/0", 4'd9, 4'd0, 6, 15, 9);
    last_q = 15;
`endif

    // Start pulse during RUN must be ignored.
    launch(4'd14, 4'd3);
    tick();
    bus.A     = 4'd1;
    bus.B     = 4'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("14/3 Q held during RUN", bus.Q, last_q);
    wait_done(3, cyc, nb);
    chk("14/3 latency", cyc, 6);
    chk("14/3 Q", bus.Q, 4);
    chk("14/3 R", bus.R, 2);
    tick();
    chk("14/3 done single pulse", bus.done, 0);
    tick();
    chk("14/3 no second op", bus.busy, 0);

    // Asynchronous reset in the middle of RUN.
    launch(4'd12, 4'd5);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("abort Q", bus.Q, 0);
    chk("abort R", bus.R, 0);
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    chk("abort no done", saw_done, 0);
    run_div("12/5", 4'd12, 4'd5, 6, 2, 2);

    // Start held high: one result every 7 cycles.
    bus.A     = 4'd10;
    bus.B     = 4'd3;
    bus.start = 1'b1;
    tick();
    ndone = 0;
    for (int c = 1; c <= 21; c++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        chk($sformatf("cont done#%0d cycle", ndone), c, 6 + 7 * (ndone - 1));
        chk($sformatf("cont done#%0d Q", ndone), bus.Q, 3);
        chk($sformatf("cont done#%0d R", ndone), bus.R, 1);
      end
      tick();
    end
    chk("cont done count", ndone, 3);
    bus.start = 1'b0;
    wait_done(1, cyc, nb);
    chk("cont drain latency", cyc, 6);
    chk("cont drain Q", bus.Q, 3);
    chk("cont drain R", bus.R, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
